capi_dma_intr_mc: RTL and testbench
===================================

Name: capi_dma_intr_mc

Overview:
- Multi-channel successor to the single-channel CAPI interrupt requester.
- Accepts interrupt requests from nch independent sources and arbitrates round-robin among them.
- Allocates a local tag from a parametrised pool and issues CAPI interrupt commands.
- Tracks each outstanding tag's originating channel and payload, retries on nonzero response code up to max_retry, and routes completion or failure back to the originating channel.

Parameters:
- nch, 4, number of requesting channels (1..8)
- ltag_width, 3, log2 of outstanding-tag pool depth
- max_retry, 2, reissues allowed per request after nonzero rc (0..7)
- ctag_width, 8, CAPI tag width; must be >= ltag_width
- ctxtid_width, 16, context id width
- irqsrc_width, 11, interrupt source number width
- aux_width, 1, aux field width
- tsize_width, 12, tsize field width
- ea_width, 64, effective address width
- sid_width, 1, sid field width
- uid_width, 1, uid field width
- uid, 0, constant uid value placed in each command
- rc_width, 1, response code width
- creq_width, ctag_width+uid_width+sid_width+1+aux_width+ctxtid_width+tsize_width+ea_width, command width

Ports:
- clk  in  1  clock; only clock.
- reset_n  in  1  asynchronous active-low reset.
- i_req_v  in  nch  per-channel request valid.
- i_req_r  out  nch  per-channel request ready.
- i_req_d_ctxt  in  nch*ctxtid_width  per-channel context; channel 0 in the MSB slice.
- i_req_d_src  in  nch*irqsrc_width  per-channel irq source.
- i_req_d_aux  in  nch*aux_width  per-channel aux.
- o_req_v  out  1  command valid.
- o_req_r  in  1  command ready.
- o_req_d  out  creq_width  command.
- i_rsp_v  in  1  response valid.
- i_rsp_ctag  in  ctag_width  response tag.
- i_rsp_rc  in  rc_width  response code; 0 = success.
- o_rsp_v  out  nch  per-channel completion pulse.
- o_rsp_fail  out  nch  per-channel failure pulse after retries are exhausted.
- o_rm_err  out  1  pulse on response to a non-outstanding tag.
- o_outst  out  ltag_width+1  count of outstanding tags.

Behaviour:
- Reset (async assert, sync deassert use): all outputs 0; tag pool all free; retry bitmap clear; round-robin pointer at channel 0.
- Command register: single entry holding o_req_v/o_req_d. It may load when empty or when o_req_r=1 in the same cycle, giving full throughput. o_req_d holds stable while o_req_v=1 and o_req_r=0.
- Source priority into the register: pending retry (lowest tag first) over new requests.
- New request acceptance: requires a free tag, register loadable, and no retry pending. Exactly one i_req_r bit is high: the round-robin winner among valid channels. The pointer moves to winner+1 (mod nch) on acceptance.
- i_req_r is combinational and must not depend on i_req_v of the same channel except through arbitration.
- Tag allocation: lowest-index free tag. Per-tag store holds channel, ctxt, src, aux and retry count (reset to 0).
- Command format: {ctag (zero-extended ltag), uid, sid=0, 1'b1, aux, ctxt, tsize=0x80, ea}.
  - ea = {zeros, src, par}.
  - par = XOR of ea[0:ea_width-2] (even parity).
- Latency: request accepted in cycle N gives o_req_v in cycle N+1.
- Response, tag outstanding, rc=0: free the tag; pulse o_rsp_v[channel] in the next cycle.
- Response, rc!=0 and retry count < max_retry: increment the count; set the retry bit; tag stays allocated. The reissued command is identical to the original except for the ctag-independent fields, which are unchanged.
- Response, rc!=0 and count = max_retry: free the tag; pulse o_rsp_fail[channel] next cycle.
- Response to a free tag, or ctag upper bits nonzero: o_rm_err pulses next cycle; no state change.
- Response for tag T while T's retry bit is still set: o_rm_err; ignored.
- A tag freed in cycle N is allocatable from N+1; free and allocate in the same cycle never alias.
- o_outst is registered: +1 on allocate, -1 on free, unchanged when both happen in one cycle.
- Pool full: all i_req_r=0; retries still issue.
- Reset mid-operation: all state discarded; no pulses are generated for lost tags.

Test Plan:
- Single request, ch2 src=0x155 ctxt=0x1234; hold o_req_r=1 -> o_req_v one cycle later, ctag=0, tsize=0x80, ea[52:62]=0x155, parity correct; rsp rc=0 -> o_rsp_v=0b0010 (ch2), o_outst 1->0.
- All 4 channels valid continuously, 2^3 tags, responses returned immediately -> grants in order 0,1,2,3,0,…; no channel starved; o_outst never exceeds 8.
- Issue 8 requests with no responses -> i_req_r=0; one rsp tag 5 -> next accepted request gets ctag 5 in the following cycle.
- Tag 0 returns rc=1 three times with max_retry=2 -> two identical reissues with ctag 0 ahead of pending new requests, then an o_rsp_fail pulse on the owning channel and the tag freed.
- Response to free tag 3, and a response with ctag=0x80 -> o_rm_err pulses; o_outst and all o_rsp outputs unchanged.
- o_req_r held 0 for 10 cycles with a request pending -> o_req_d stable; assert reset_n=0 mid-stall -> all outputs 0 immediately, o_outst=0.

Source files
------------

// File: rtl/capi_dma_intr_mc.sv
// Multi-channel CAPI interrupt requester: round-robin arbitration over nch sources,
// local tag pool with retry on nonzero rc, completion/failure routed to the owning channel.
module capi_dma_intr_mc #(
    parameter int unsigned nch          = 4,
    parameter int unsigned ltag_width   = 3,
    parameter int unsigned max_retry    = 2,
    parameter int unsigned ctag_width   = 8,
    parameter int unsigned ctxtid_width = 16,
    parameter int unsigned irqsrc_width = 11,
    parameter int unsigned aux_width    = 1,
    parameter int unsigned tsize_width  = 12,
    parameter int unsigned ea_width     = 64,
    parameter int unsigned sid_width    = 1,
    parameter int unsigned uid_width    = 1,
    parameter int unsigned uid          = 0,
    parameter int unsigned rc_width     = 1,
    parameter int unsigned creq_width   = ctag_width + uid_width + sid_width + 1 + aux_width
                                          + ctxtid_width + tsize_width + ea_width
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [nch-1:0]                 i_req_v,
    output logic [nch-1:0]                 i_req_r,
    input  logic [nch*ctxtid_width-1:0]    i_req_d_ctxt,
    input  logic [nch*irqsrc_width-1:0]    i_req_d_src,
    input  logic [nch*aux_width-1:0]       i_req_d_aux,
    output logic                           o_req_v,
    input  logic                           o_req_r,
    output logic [creq_width-1:0]          o_req_d,
    input  logic                           i_rsp_v,
    input  logic [ctag_width-1:0]          i_rsp_ctag,
    input  logic [rc_width-1:0]            i_rsp_rc,
    output logic [nch-1:0]                 o_rsp_v,
    output logic [nch-1:0]                 o_rsp_fail,
    output logic                           o_rm_err,
    output logic [ltag_width:0]            o_outst
);

    localparam int unsigned ntag = 1 << ltag_width;
    localparam int unsigned chw  = (nch > 1) ? $clog2(nch) : 1;
    localparam int unsigned cntw = 3;
    localparam int unsigned ow   = ltag_width + 1;

    logic                    req_v_q, req_v_d;
    logic [creq_width-1:0]   req_d_q, req_d_d;
    logic [ntag-1:0]         busy_q, busy_d, retry_q, retry_d;
    logic [chw-1:0]          t_ch_q   [ntag];
    logic [chw-1:0]          t_ch_d   [ntag];
    logic [ctxtid_width-1:0] t_ctxt_q [ntag];
    logic [ctxtid_width-1:0] t_ctxt_d [ntag];
    logic [irqsrc_width-1:0] t_src_q  [ntag];
    logic [irqsrc_width-1:0] t_src_d  [ntag];
    logic [aux_width-1:0]    t_aux_q  [ntag];
    logic [aux_width-1:0]    t_aux_d  [ntag];
    logic [cntw-1:0]         t_cnt_q  [ntag];
    logic [cntw-1:0]         t_cnt_d  [ntag];
    logic [chw-1:0]          rr_q, rr_d;
    logic [ow-1:0]           outst_q, outst_d;
    logic [nch-1:0]          rsp_v_q, rsp_v_d, rsp_fail_q, rsp_fail_d;
    logic                    rm_err_q, rm_err_d;

    logic [nch-1:0]          req_v_ch;
    logic                    load_ok, win_v, alloc, free, ctag_hi;
    logic [chw-1:0]          win, cand;
    logic [ltag_width-1:0]   rtag, ftag, rt;
    logic [ctxtid_width-1:0] w_ctxt;
    logic [irqsrc_width-1:0] w_src;
    logic [aux_width-1:0]    w_aux;

    // Command word; ea carries src above an even-parity bit over everything else.
    function automatic logic [creq_width-1:0] mk_cmd(input logic [ltag_width-1:0]   tag,
                                                     input logic [aux_width-1:0]    aux,
                                                     input logic [ctxtid_width-1:0] ctxt,
                                                     input logic [irqsrc_width-1:0] src);
        logic [ea_width-1:0] ea;
        ea                 = '0;
        ea[irqsrc_width:1] = src;
        ea[0]              = ^src;
        return {ctag_width'(tag), uid_width'(uid), sid_width'(0), 1'b1, aux, ctxt,
                tsize_width'(128), ea};
    endfunction

    // Channel 0 occupies the MSB of every per-channel vector.
    function automatic logic [nch-1:0] ch_bit(input logic [chw-1:0] c);
        logic [nch-1:0] r;
        r = '0;
        for (int k = 0; k < int'(nch); k++) begin
            if (c == chw'(k)) r[nch-1-k] = 1'b1;
        end
        return r;
    endfunction

    if (ctag_width > ltag_width) begin : g_hi
        assign ctag_hi = |i_rsp_ctag[ctag_width-1:ltag_width];
    end else begin : g_nohi
        assign ctag_hi = 1'b0;
    end

    always_comb begin
        for (int c = 0; c < int'(nch); c++) req_v_ch[c] = i_req_v[nch-1-c];
    end

    always_comb begin
        busy_d     = busy_q;
        retry_d    = retry_q;
        t_ch_d     = t_ch_q;
        t_ctxt_d   = t_ctxt_q;
        t_src_d    = t_src_q;
        t_aux_d    = t_aux_q;
        t_cnt_d    = t_cnt_q;
        req_v_d    = req_v_q & ~o_req_r;
        req_d_d    = req_d_q;
        rr_d       = rr_q;
        rsp_v_d    = '0;
        rsp_fail_d = '0;
        rm_err_d   = 1'b0;
        alloc      = 1'b0;
        free       = 1'b0;
        i_req_r    = '0;
        cand       = '0;
        win_v      = 1'b0;
        win        = '0;
        w_ctxt     = '0;
        w_src      = '0;
        w_aux      = '0;
        rtag       = '0;
        ftag       = '0;
        load_ok    = ~req_v_q | o_req_r;

        for (int t = int'(ntag) - 1; t >= 0; t--) begin
            if (retry_q[t]) rtag = ltag_width'(t);
            if (!busy_q[t]) ftag = ltag_width'(t);
        end

        // Round-robin: the first valid channel at or after rr_q wins.
        for (int i = int'(nch) - 1; i >= 0; i--) begin
            cand = chw'((int'(rr_q) + i) % int'(nch));
            if (req_v_ch[cand]) begin
                win_v = 1'b1;
                win   = cand;
            end
        end

        for (int c = 0; c < int'(nch); c++) begin
            if (win == chw'(c)) begin
                w_ctxt = i_req_d_ctxt[(nch-1-c)*ctxtid_width +: ctxtid_width];
                w_src  = i_req_d_src[(nch-1-c)*irqsrc_width +: irqsrc_width];
                w_aux  = i_req_d_aux[(nch-1-c)*aux_width +: aux_width];
            end
        end

        if (load_ok && (|retry_q)) begin
            req_v_d       = 1'b1;
            req_d_d       = mk_cmd(rtag, t_aux_q[rtag], t_ctxt_q[rtag], t_src_q[rtag]);
            retry_d[rtag] = 1'b0;
        end else if (load_ok && !(&busy_q) && win_v) begin
            alloc          = 1'b1;
            req_v_d        = 1'b1;
            req_d_d        = mk_cmd(ftag, w_aux, w_ctxt, w_src);
            busy_d[ftag]   = 1'b1;
            t_ch_d[ftag]   = win;
            t_ctxt_d[ftag] = w_ctxt;
            t_src_d[ftag]  = w_src;
            t_aux_d[ftag]  = w_aux;
            t_cnt_d[ftag]  = '0;
            rr_d           = (int'(win) == int'(nch) - 1) ? '0 : win + 1'b1;
        end

        if (alloc && reset_n) i_req_r = ch_bit(win);

        // Responses act on pre-cycle state, so a freed tag is only reusable next cycle.
        rt = i_rsp_ctag[ltag_width-1:0];
        if (i_rsp_v) begin
            if (ctag_hi || !busy_q[rt] || retry_q[rt]) begin
                rm_err_d = 1'b1;
            end else if (i_rsp_rc == '0) begin
                busy_d[rt] = 1'b0;
                free       = 1'b1;
                rsp_v_d    = ch_bit(t_ch_q[rt]);
            end else if (t_cnt_q[rt] < cntw'(max_retry)) begin
                t_cnt_d[rt] = t_cnt_q[rt] + 1'b1;
                retry_d[rt] = 1'b1;
            end else begin
                busy_d[rt] = 1'b0;
                free       = 1'b1;
                rsp_fail_d = ch_bit(t_ch_q[rt]);
            end
        end

        outst_d = outst_q + ow'(alloc) - ow'(free);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_v_q    <= 1'b0;
            req_d_q    <= '0;
            busy_q     <= '0;
            retry_q    <= '0;
            rr_q       <= '0;
            outst_q    <= '0;
            rsp_v_q    <= '0;
            rsp_fail_q <= '0;
            rm_err_q   <= 1'b0;
            for (int t = 0; t < int'(ntag); t++) begin
                t_ch_q[t]   <= '0;
                t_ctxt_q[t] <= '0;
                t_src_q[t]  <= '0;
                t_aux_q[t]  <= '0;
                t_cnt_q[t]  <= '0;
            end
        end else begin
            req_v_q    <= req_v_d;
            req_d_q    <= req_d_d;
            busy_q     <= busy_d;
            retry_q    <= retry_d;
            rr_q       <= rr_d;
            outst_q    <= outst_d;
            rsp_v_q    <= rsp_v_d;
            rsp_fail_q <= rsp_fail_d;
            rm_err_q   <= rm_err_d;
            t_ch_q     <= t_ch_d;
            t_ctxt_q   <= t_ctxt_d;
            t_src_q    <= t_src_d;
            t_aux_q    <= t_aux_d;
            t_cnt_q    <= t_cnt_d;
        end
    end

    assign o_req_v    = req_v_q;
    assign o_req_d    = req_d_q;
    assign o_rsp_v    = rsp_v_q;
    assign o_rsp_fail = rsp_fail_q;
    assign o_rm_err   = rm_err_q;
    assign o_outst    = outst_q;

endmodule

// File: tb/tb_capi_dma_intr_mc.sv
// Bench for capi_dma_intr_mc: directed scenarios plus randomized traffic against a
// tag-table reference model.
module tb_capi_dma_intr_mc;

    localparam int NCH  = 4;
    localparam int NTAG = 8;
    localparam int MAXR = 2;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   i_req_v;
    logic [3:0]   i_req_r;
    logic [63:0]  i_req_d_ctxt;
    logic [43:0]  i_req_d_src;
    logic [3:0]   i_req_d_aux;
    logic         o_req_v;
    logic         o_req_r;
    logic [103:0] o_req_d;
    logic         i_rsp_v;
    logic [7:0]   i_rsp_ctag;
    logic         i_rsp_rc;
    logic [3:0]   o_rsp_v;
    logic [3:0]   o_rsp_fail;
    logic         o_rm_err;
    logic [3:0]   o_outst;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    capi_dma_intr_mc dut (
        .clk(clk), .reset_n(reset_n),
        .i_req_v(i_req_v), .i_req_r(i_req_r),
        .i_req_d_ctxt(i_req_d_ctxt), .i_req_d_src(i_req_d_src), .i_req_d_aux(i_req_d_aux),
        .o_req_v(o_req_v), .o_req_r(o_req_r), .o_req_d(o_req_d),
        .i_rsp_v(i_rsp_v), .i_rsp_ctag(i_rsp_ctag), .i_rsp_rc(i_rsp_rc),
        .o_rsp_v(o_rsp_v), .o_rsp_fail(o_rsp_fail), .o_rm_err(o_rm_err), .o_outst(o_outst)
    );

    // Reference model: a table of outstanding tags and their owners.
    bit          m_busy  [NTAG];
    bit          m_retry [NTAG];
    int          m_ch    [NTAG];
    int          m_cnt   [NTAG];
    logic [15:0] m_ctxt  [NTAG];
    logic [10:0] m_src   [NTAG];
    logic        m_aux   [NTAG];
    int          m_rr;
    bit          m_reg_v;
    logic [103:0] m_reg_d;
    int          m_outst;
    logic [3:0]  m_rsp_v, m_rsp_fail;
    bit          m_rm_err;
    int          m_win;
    logic [3:0]  m_req_r;

    function automatic logic [103:0] exp_cmd(input int t);
        logic [63:0] ea;
        ea    = 64'(m_src[t]) * 2;
        ea[0] = ($countones(m_src[t]) % 2) == 1;
        return {8'(t), 1'b0, 1'b0, 1'b1, m_aux[t], m_ctxt[t], 12'h080, ea};
    endfunction

    task automatic model_reset();
        for (int t = 0; t < NTAG; t++) begin
            m_busy[t] = 0; m_retry[t] = 0; m_ch[t] = 0; m_cnt[t] = 0;
            m_ctxt[t] = '0; m_src[t] = '0; m_aux[t] = 1'b0;
        end
        m_rr = 0; m_reg_v = 0; m_reg_d = '0; m_outst = 0;
        m_rsp_v = '0; m_rsp_fail = '0; m_rm_err = 0; m_win = -1; m_req_r = '0;
    endtask

    task automatic model_comb();
        bit load_ok, rp, fr;
        load_ok = !m_reg_v || o_req_r;
        rp = 0; fr = 0;
        for (int t = 0; t < NTAG; t++) begin
            rp |= m_retry[t];
            fr |= !m_busy[t];
        end
        m_win = -1;
        if (load_ok && !rp && fr) begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_rr + k) % NCH;
                if (m_win < 0 && i_req_v[3-c]) m_win = c;
            end
        end
        m_req_r = (m_win < 0) ? 4'b0000 : (4'b1000 >> m_win);
    endtask

    task automatic model_step();
        bit load_ok;
        int rt, ft, t;
        load_ok = !m_reg_v || o_req_r;
        rt = -1; ft = -1;
        for (int k = NTAG - 1; k >= 0; k--) begin
            if (m_retry[k]) rt = k;
            if (!m_busy[k]) ft = k;
        end
        m_rsp_v = '0; m_rsp_fail = '0; m_rm_err = 0;
        if (i_rsp_v) begin
            t = int'(i_rsp_ctag) % NTAG;
            if (i_rsp_ctag >= 8'd8 || !m_busy[t] || m_retry[t]) m_rm_err = 1;
            else if (i_rsp_rc == 1'b0) begin
                m_busy[t] = 0; m_rsp_v[3-m_ch[t]] = 1'b1; m_outst--;
            end else if (m_cnt[t] < MAXR) begin
                m_cnt[t]++; m_retry[t] = 1;
            end else begin
                m_busy[t] = 0; m_rsp_fail[3-m_ch[t]] = 1'b1; m_outst--;
            end
        end
        if (o_req_r) m_reg_v = 0;
        if (load_ok && rt >= 0) begin
            m_reg_v = 1; m_reg_d = exp_cmd(rt); m_retry[rt] = 0;
        end else if (m_win >= 0) begin
            m_busy[ft] = 1; m_ch[ft] = m_win; m_cnt[ft] = 0;
            m_ctxt[ft] = i_req_d_ctxt[(3-m_win)*16 +: 16];
            m_src[ft]  = i_req_d_src[(3-m_win)*11 +: 11];
            m_aux[ft]  = i_req_d_aux[3-m_win];
            m_outst++;
            m_reg_v = 1; m_reg_d = exp_cmd(ft);
            m_rr = (m_win + 1) % NCH;
        end
    endtask

    task automatic settle();
        #1;
        model_comb();
    endtask

    task automatic tick();
        model_comb();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        i_req_v = '0; i_rsp_v = 1'b0; i_rsp_ctag = '0; i_rsp_rc = 1'b0; o_req_r = 1'b1;
    endtask

    task automatic rand_data();
        i_req_d_ctxt = {$urandom, $urandom};
        i_req_d_src  = {$urandom, 12'($urandom)};
        i_req_d_aux  = 4'($urandom);
    endtask

    task automatic set_ch(input int c, input logic [15:0] ctxt, input logic [10:0] src,
                          input logic aux);
        i_req_d_ctxt[(3-c)*16 +: 16] = ctxt;
        i_req_d_src[(3-c)*11 +: 11]  = src;
        i_req_d_aux[3-c]             = aux;
    endtask

    task automatic reset_dut();
        reset_n = 1'b1;
        drive_idle();
        rand_data();
        #1 reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        drive_idle();
        rand_data();
        #1 reset_n = 1'b0;
        i_req_v = 4'hF;
        #1;
        checks++;
        if ({o_req_v, o_req_d, o_rsp_v, o_rsp_fail, o_rm_err, o_outst, i_req_r} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: req_v=%b req_d=%h outst=%0d req_r=%b want all 0",
                     o_req_v, o_req_d, o_outst, i_req_r);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        settle();
        checks++;
        if (i_req_r !== 4'b1000) begin
            failures++;
            $display("FAIL reset_rr_ch0: i_req_r=%b want 1000", i_req_r);
        end
        i_req_v = '0;
    endtask

    task automatic test_single();
        reset_dut();
        set_ch(2, 16'h1234, 11'h155, 1'b0);
        i_req_v = 4'b0010;
        settle();
        checks++;
        if (i_req_r !== 4'b0010) begin
            failures++; $display("FAIL single_grant: i_req_r=%b want 0010", i_req_r);
        end
        tick();
        checks++;
        if (o_req_v !== 1'b1 || o_req_d !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 12'h080, 64'h2AB}) begin
            failures++; $display("FAIL single_cmd: v=%b d=%h", o_req_v, o_req_d);
        end
        checks++;
        if (o_outst !== 4'd1) begin
            failures++; $display("FAIL single_outst1: outst=%0d want 1", o_outst);
        end
        i_req_v = '0; i_rsp_v = 1'b1; i_rsp_ctag = 8'h00; i_rsp_rc = 1'b0;
        tick();
        checks++;
        if (o_rsp_v !== 4'b0010 || o_outst !== 4'd0 || o_req_v !== 1'b0) begin
            failures++;
            $display("FAIL single_rsp: rsp_v=%b outst=%0d req_v=%b want 0010 0 0", o_rsp_v, o_outst, o_req_v);
        end
        drive_idle();
        tick();
        checks++;
        if (o_rsp_v !== 4'b0000) begin
            failures++; $display("FAIL single_pulse: rsp_v=%b want 0000", o_rsp_v);
        end
    endtask

    task automatic test_round_robin();
        int cnt [NCH];
        reset_dut();
        for (int c = 0; c < NCH; c++) cnt[c] = 0;
        i_req_v = 4'hF;
        for (int k = 0; k < 16; k++) begin
            rand_data();
            i_rsp_v = m_reg_v; i_rsp_ctag = m_reg_d[103:96]; i_rsp_rc = 1'b0;
            settle();
            checks++;
            if (i_req_r !== (4'b1000 >> (k % 4))) begin
                failures++; $display("FAIL rr_order[%0d]: i_req_r=%b want %b", k, i_req_r, 4'b1000 >> (k % 4));
            end
            for (int c = 0; c < NCH; c++) if (i_req_r[3-c]) cnt[c]++;
            tick();
            checks++;
            if (o_outst > 4'd8 || o_outst !== 4'(m_outst)) begin
                failures++; $display("FAIL rr_outst[%0d]: outst=%0d want %0d", k, o_outst, m_outst);
            end
        end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (cnt[c] != 4) begin
                failures++; $display("FAIL rr_starve ch%0d: grants=%0d want 4", c, cnt[c]);
            end
        end
        drive_idle();
    endtask

    task automatic test_pool_full();
        reset_dut();
        i_req_v = 4'b1000;
        for (int k = 0; k < NTAG; k++) begin
            rand_data();
            tick();
            checks++;
            if (o_req_d[103:96] !== 8'(k)) begin
                failures++; $display("FAIL pool_alloc[%0d]: ctag=%0d want %0d", k, o_req_d[103:96], k);
            end
        end
        settle();
        checks++;
        if (i_req_r !== 4'b0000 || o_outst !== 4'd8) begin
            failures++; $display("FAIL pool_full: i_req_r=%b outst=%0d want 0000 8", i_req_r, o_outst);
        end
        tick();
        i_rsp_v = 1'b1; i_rsp_ctag = 8'd5; i_rsp_rc = 1'b0;
        settle();
        checks++;
        if (i_req_r !== 4'b0000) begin
            failures++; $display("FAIL pool_free_same_cycle: i_req_r=%b want 0000", i_req_r);
        end
        tick();
        i_rsp_v = 1'b0;
        checks++;
        if (o_rsp_v !== 4'b1000 || o_outst !== 4'd7) begin
            failures++; $display("FAIL pool_rsp5: rsp_v=%b outst=%0d want 1000 7", o_rsp_v, o_outst);
        end
        settle();
        checks++;
        if (i_req_r !== 4'b1000) begin
            failures++; $display("FAIL pool_regrant: i_req_r=%b want 1000", i_req_r);
        end
        tick();
        checks++;
        if (o_req_v !== 1'b1 || o_req_d[103:96] !== 8'd5 || o_outst !== 4'd8) begin
            failures++; $display("FAIL pool_reuse5: ctag=%0d outst=%0d want 5 8", o_req_d[103:96], o_outst);
        end
        drive_idle();
    endtask

    task automatic test_retry();
        logic [103:0] orig;
        reset_dut();
        set_ch(1, 16'($urandom), 11'($urandom), 1'($urandom));
        i_req_v = 4'b0100;
        tick();
        orig = m_reg_d;
        checks++;
        if (o_req_v !== 1'b1 || o_req_d !== orig) begin
            failures++; $display("FAIL retry_first: d=%h want %h", o_req_d, orig);
        end
        for (int r = 0; r < MAXR; r++) begin
            i_req_v = '0; i_rsp_v = 1'b1; i_rsp_ctag = 8'd0; i_rsp_rc = 1'b1;
            tick();
            i_rsp_v = 1'b0; i_req_v = 4'b0001;
            rand_data();
            settle();
            checks++;
            if (i_req_r !== 4'b0000) begin
                failures++; $display("FAIL retry_priority[%0d]: i_req_r=%b want 0000", r, i_req_r);
            end
            tick();
            checks++;
            if (o_req_v !== 1'b1 || o_req_d !== orig) begin
                failures++; $display("FAIL retry_reissue[%0d]: d=%h want %h", r, o_req_d, orig);
            end
        end
        i_req_v = '0; i_rsp_v = 1'b1; i_rsp_ctag = 8'd0; i_rsp_rc = 1'b1;
        tick();
        i_rsp_v = 1'b0;
        checks++;
        if (o_rsp_fail !== 4'b0100 || o_rsp_v !== 4'b0000 || o_outst !== 4'd0) begin
            failures++;
            $display("FAIL retry_fail: fail=%b rsp_v=%b outst=%0d want 0100 0000 0", o_rsp_fail, o_rsp_v, o_outst);
        end
        i_req_v = 4'b0001;
        settle();
        checks++;
        if (i_req_r !== 4'b0001) begin
            failures++; $display("FAIL retry_after: i_req_r=%b want 0001", i_req_r);
        end
        tick();
        checks++;
        if (o_req_d[103:96] !== 8'd0 || o_outst !== 4'd1) begin
            failures++; $display("FAIL retry_tag_freed: ctag=%0d outst=%0d want 0 1", o_req_d[103:96], o_outst);
        end
        drive_idle();
    endtask

    task automatic test_rm_err();
        reset_dut();
        i_req_v = 4'b1000;
        tick();
        i_req_v = '0;
        for (int k = 0; k < 2; k++) begin
            i_rsp_v = 1'b1; i_rsp_rc = 1'b0;
            i_rsp_ctag = (k == 0) ? 8'd3 : 8'h80;
            tick();
            checks++;
            if (o_rm_err !== 1'b1 || o_rsp_v !== 4'b0000 || o_rsp_fail !== 4'b0000 || o_outst !== 4'd1) begin
                failures++;
                $display("FAIL rm_err[%0d]: rm_err=%b rsp_v=%b fail=%b outst=%0d want 1 0000 0000 1",
                         k, o_rm_err, o_rsp_v, o_rsp_fail, o_outst);
            end
        end
        i_rsp_ctag = 8'd0;
        tick();
        checks++;
        if (o_rm_err !== 1'b0 || o_rsp_v !== 4'b1000 || o_outst !== 4'd0) begin
            failures++; $display("FAIL rm_cleanup: rm_err=%b rsp_v=%b outst=%0d want 0 1000 0", o_rm_err, o_rsp_v, o_outst);
        end
        drive_idle();
    endtask

    task automatic test_stall_reset();
        reset_dut();
        o_req_r = 1'b0;
        i_req_v = 4'b0010;
        tick();
        i_req_v = 4'hF;
        for (int k = 0; k < 10; k++) begin
            rand_data();
            settle();
            checks++;
            if (i_req_r !== 4'b0000) begin
                failures++; $display("FAIL stall_ready[%0d]: i_req_r=%b want 0000", k, i_req_r);
            end
            tick();
            checks++;
            if (o_req_v !== 1'b1 || o_req_d !== m_reg_d) begin
                failures++; $display("FAIL stall_hold[%0d]: v=%b d=%h want 1 %h", k, o_req_v, o_req_d, m_reg_d);
            end
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({o_req_v, o_req_d, o_rsp_v, o_rsp_fail, o_rm_err, o_outst, i_req_r} !== '0) begin
            failures++;
            $display("FAIL stall_reset: req_v=%b outst=%0d req_r=%b want all 0", o_req_v, o_outst, i_req_r);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        o_req_r = 1'b1;
        settle();
        checks++;
        if (o_outst !== 4'd0 || i_req_r !== 4'b1000) begin
            failures++; $display("FAIL stall_restart: outst=%0d req_r=%b want 0 1000", o_outst, i_req_r);
        end
        drive_idle();
    endtask

    task automatic test_random();
        int q[$];
        reset_dut();
        for (int k = 0; k < 400; k++) begin
            rand_data();
            i_req_v = 4'($urandom);
            o_req_r = ($urandom_range(0, 3) != 0);
            i_rsp_v = ($urandom_range(0, 2) != 0);
            i_rsp_rc = ($urandom_range(0, 3) == 0);
            q.delete();
            for (int t = 0; t < NTAG; t++) if (m_busy[t]) q.push_back(t);
            if ($urandom_range(0, 9) == 0) i_rsp_ctag = 8'($urandom_range(8, 255));
            else if (q.size() > 0 && $urandom_range(0, 4) != 0)
                i_rsp_ctag = 8'(q[$urandom_range(0, q.size() - 1)]);
            else i_rsp_ctag = 8'($urandom_range(0, 7));
            settle();
            checks++;
            if (i_req_r !== m_req_r) begin
                failures++; $display("FAIL rand_ready[%0d]: i_req_r=%b want %b", k, i_req_r, m_req_r);
            end
            tick();
            checks++;
            if ({o_req_v, o_rsp_v, o_rsp_fail, o_rm_err, o_outst} !==
                {m_reg_v, m_rsp_v, m_rsp_fail, m_rm_err, 4'(m_outst)}) begin
                failures++;
                $display("FAIL rand_out[%0d]: v=%b rsp=%b fail=%b rm=%b outst=%0d want %b %b %b %b %0d",
                         k, o_req_v, o_rsp_v, o_rsp_fail, o_rm_err, o_outst,
                         m_reg_v, m_rsp_v, m_rsp_fail, m_rm_err, m_outst);
            end
            if (m_reg_v) begin
                checks++;
                if (o_req_d !== m_reg_d) begin
                    failures++; $display("FAIL rand_cmd[%0d]: d=%h want %h", k, o_req_d, m_reg_d);
                end
            end
        end
        drive_idle();
    endtask

    initial begin
        reset_n = 1'b1;
        drive_idle();
        rand_data();
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_pool_full();
        test_retry();
        test_rm_err();
        test_stall_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
